// File: rtl/sys_bus_interconnect.sv
// ---------------------------------------------------------------------------
// sys_bus_interconnect
//
// Fans the single system-bus master port out to SN subordinate register
// blocks, chosen by the address field m_addr[AB +: SL]. One access is
// tracked at a time; each accepted access returns exactly one registered
// m_ack with m_rdata. Unpopulated slots (MASK bit clear) are answered
// locally with zero data. Acks from other slots, acks while idle and acks
// that arrive after a timeout or an abandoned access are dropped.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   m_wen, m_ren       upstream write/read strobes (1-cycle pulses)
//   m_addr, m_wdata    upstream address / write data, valid with a strobe
//   m_rdata, m_ack     read data and completion pulse back to upstream
//   s_wen, s_ren       per-slot strobes, one-hot or zero
//   s_addr, s_wdata    registered address / write data shared by all slots
//   s_rdata            slot i read data in bits [i*DW +: DW]
//   s_ack              per-slot completion
// ---------------------------------------------------------------------------
module sys_bus_interconnect #(
    parameter int            DW   = 32,
    parameter int            AW   = 32,
    parameter int            SN   = 8,
    parameter int            AB   = 20,
    parameter logic [SN-1:0] MASK = '1,
    parameter int            TMO  = 40
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             m_wen,
    input  logic             m_ren,
    input  logic [AW-1:0]    m_addr,
    input  logic [DW-1:0]    m_wdata,
    output logic [DW-1:0]    m_rdata,
    output logic             m_ack,
    output logic [SN-1:0]    s_wen,
    output logic [SN-1:0]    s_ren,
    output logic [AW-1:0]    s_addr,
    output logic [DW-1:0]    s_wdata,
    input  logic [SN*DW-1:0] s_rdata,
    input  logic [SN-1:0]    s_ack
);

    localparam int SL = $clog2(SN);
    localparam int CW = $clog2(TMO);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    state_t        state;
    logic [SL-1:0] sel_q;
    logic          rd_q;
    logic [CW-1:0] tmo_cnt;

    logic [SL-1:0] sel;
    logic          req;
    logic          pop_q;
    logic          done;

    assign sel   = m_addr[AB +: SL];
    assign req   = m_wen | m_ren;
    assign pop_q = MASK[sel_q];
    // An unpopulated slot completes on its own in the first PEND cycle,
    // which lines its m_ack up with a zero-latency populated slot.
    assign done  = pop_q ? s_ack[sel_q] : 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            sel_q   <= '0;
            rd_q    <= 1'b0;
            tmo_cnt <= '0;
            s_wen   <= '0;
            s_ren   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            m_ack   <= 1'b0;
            m_rdata <= '0;
        end else begin
            s_wen <= '0;
            s_ren <= '0;
            m_ack <= 1'b0;
            // A new request always wins: it abandons any pending access, so
            // a same-cycle ack from the old slot is never looked at.
            if (req) begin
                s_addr  <= m_addr;
                s_wdata <= m_wdata;
                sel_q   <= sel;
                rd_q    <= m_ren & ~m_wen;
                state   <= PEND;
                tmo_cnt <= '0;
                if (MASK[sel]) begin
                    if (m_wen) begin
                        s_wen[sel] <= 1'b1;
                    end else begin
                        s_ren[sel] <= 1'b1;
                    end
                end
            end else if (state == PEND) begin
                if (done) begin
                    m_ack   <= 1'b1;
                    m_rdata <= (rd_q && pop_q) ? s_rdata[sel_q*DW +: DW] : '0;
                    state   <= IDLE;
                end else if (tmo_cnt == CW'(TMO - 1)) begin
                    state <= IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_interconnect
//
// Scenario tasks drive the master port and play the subordinates. Expected
// strobes, ack timing and read data are worked out from the slot number,
// the access kind and the chosen ack latency. Slot 7 is left unpopulated.
// ---------------------------------------------------------------------------
module tb_sys_bus_interconnect;

    localparam int            DW  = 32;
    localparam int            AW  = 32;
    localparam int            SN  = 8;
    localparam logic [SN-1:0] MSK = 8'b0111_1111;

    logic             clk = 1'b0;
    logic             rstn;
    logic             m_wen, m_ren;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic [DW-1:0]    m_rdata;
    logic             m_ack;
    logic [SN-1:0]    s_wen, s_ren;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [SN*DW-1:0] s_rdata;
    logic [SN-1:0]    s_ack;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sys_bus_interconnect #(
        .DW  (DW),
        .AW  (AW),
        .SN  (SN),
        .AB  (20),
        .MASK(MSK),
        .TMO (40)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .m_wen  (m_wen),
        .m_ren  (m_ren),
        .m_addr (m_addr),
        .m_wdata(m_wdata),
        .m_rdata(m_rdata),
        .m_ack  (m_ack),
        .s_wen  (s_wen),
        .s_ren  (s_ren),
        .s_addr (s_addr),
        .s_wdata(s_wdata),
        .s_rdata(s_rdata),
        .s_ack  (s_ack)
    );

    // One complete access, entered just after a falling edge (cycle N).
    // lat = cycles after the strobe cycle at which the slot acks.
    // noise = another slot that pulses random acks while waiting (-1: none).
    // stale = slot that acks in the request cycle itself (-1: none).
    task automatic access(input string tag, input logic wr, input logic rd,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rdv, input int lat,
                          input int noise, input int stale);
        int            slot;
        logic          pop;
        int            wait_c;
        logic [SN-1:0] exp_wen, exp_ren, one;
        logic [DW-1:0] exp_rd;
        slot    = int'(addr[22:20]);
        pop     = MSK[slot];
        one     = '0;
        one[slot] = 1'b1;
        exp_wen = (wr && pop) ? one : '0;
        exp_ren = (!wr && rd && pop) ? one : '0;
        exp_rd  = (rd && !wr && pop) ? rdv : '0;
        wait_c  = pop ? lat : 0;
        for (int i = 0; i < SN; i++) s_rdata[i*DW +: DW] = $urandom;
        s_rdata[slot*DW +: DW] = rdv;
        m_wen = wr; m_ren = rd; m_addr = addr; m_wdata = wd;
        s_ack = '0;
        if (stale >= 0) s_ack[stale] = 1'b1;
        @(negedge clk);
        m_wen = 1'b0; m_ren = 1'b0; m_addr = $urandom; m_wdata = $urandom;
        s_ack = '0;
        n_cmp++;
        if (s_wen !== exp_wen) begin
            n_bad++; $display("FAIL %s s_wen got %b want %b", tag, s_wen, exp_wen);
        end
        n_cmp++;
        if (s_ren !== exp_ren) begin
            n_bad++; $display("FAIL %s s_ren got %b want %b", tag, s_ren, exp_ren);
        end
        n_cmp++;
        if (s_addr !== addr || s_wdata !== wd) begin
            n_bad++; $display("FAIL %s s_addr/s_wdata got %h/%h want %h/%h",
                              tag, s_addr, s_wdata, addr, wd);
        end
        for (int c = 0; c <= wait_c; c++) begin
            if (c > 0) begin
                n_cmp++;
                if ((s_wen | s_ren) !== '0) begin
                    n_bad++; $display("FAIL %s strobe_once c=%0d got %b want 0", tag, c, s_wen | s_ren);
                end
            end
            n_cmp++;
            if (m_ack !== 1'b0) begin
                n_bad++; $display("FAIL %s m_ack_early c=%0d got %b want 0", tag, c, m_ack);
            end
            s_ack = '0;
            if (pop && c == wait_c) s_ack[slot] = 1'b1;
            else if (noise >= 0) s_ack[noise] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        s_ack = '0;
        n_cmp++;
        if (m_ack !== 1'b1 || m_rdata !== exp_rd) begin
            n_bad++; $display("FAIL %s m_ack/m_rdata got %b/%h want 1/%h", tag, m_ack, m_rdata, exp_rd);
        end
        @(negedge clk);
        n_cmp++;
        if (m_ack !== 1'b0 || m_rdata !== exp_rd) begin
            n_bad++; $display("FAIL %s ack_once/hold got %b/%h want 0/%h", tag, m_ack, m_rdata, exp_rd);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; m_wen = 0; m_ren = 0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0;
        #1;
        n_cmp++;
        if ({s_wen, s_ren, s_addr, s_wdata, m_ack, m_rdata} !== '0) begin
            n_bad++; $display("FAIL reset outputs got %h want 0",
                              {s_wen, s_ren, s_addr, s_wdata, m_ack, m_rdata});
        end
        @(negedge clk); @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_slot3();
        access("wr3", 1'b1, 1'b0, 32'h0030_0010, 32'hA5A5_0001, 32'hFFFF_FFFF, 0, -1, -1);
    endtask

    task automatic test_read_slot5();
        access("rd5", 1'b0, 1'b1, 32'h0050_0004, 32'h0, 32'h1234_5678, 7, 2, -1);
    endtask

    task automatic test_unpopulated();
        access("unpop", 1'b0, 1'b1, 32'h0070_0000, 32'h0, 32'hCAFE_F00D, 0, -1, -1);
        access("unpop_wr", 1'b1, 1'b0, 32'h0070_0040, 32'h5555_AAAA, 32'h0, 0, -1, -1);
    endtask

    task automatic test_both_strobes();
        access("wr_rd", 1'b1, 1'b1, 32'h0060_0020, 32'h0BAD_BEEF, 32'h7777_7777, 2, -1, -1);
    endtask

    // Last accepted ack is in the 40th pending cycle (cycle N+40).
    task automatic test_timeout_boundary();
        access("ack_at_tmo", 1'b0, 1'b1, 32'h0010_0100, 32'h0, 32'h0F0F_1234, 39, -1, -1);
    endtask

    task automatic test_timeout();
        m_ren = 1'b1; m_addr = 32'h0010_0000;
        @(negedge clk);
        m_ren = 1'b0;
        n_cmp++;
        if (s_ren !== 8'b0000_0010) begin
            n_bad++; $display("FAIL tmo s_ren got %b want 00000010", s_ren);
        end
        for (int c = 1; c <= 60; c++) begin
            n_cmp++;
            if (m_ack !== 1'b0) begin
                n_bad++; $display("FAIL tmo no_ack c=%0d got %b want 0", c, m_ack);
            end
            s_ack = (c == 41 || c == 50) ? 8'b0000_0010 : 8'b0;
            @(negedge clk);
        end
        s_ack = '0;
    endtask

    task automatic test_abandon();
        m_ren = 1'b1; m_addr = 32'h0010_0008;
        @(negedge clk);
        m_ren = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            n_cmp++;
            if (m_ack !== 1'b0) begin
                n_bad++; $display("FAIL abandon no_ack c=%0d got %b want 0", c, m_ack);
            end
            @(negedge clk);
        end
        access("abandon_wr4", 1'b1, 1'b0, 32'h0040_0000, 32'h4444_0004, 32'h0, 0, -1, 1);
    endtask

    task automatic test_async_reset();
        access("pre_rst", 1'b0, 1'b1, 32'h0060_0000, 32'h0, 32'hDEAD_BEEF, 1, -1, -1);
        m_ren = 1'b1; m_addr = 32'h0020_0030;
        @(negedge clk);
        m_ren = 1'b0;
        n_cmp++;
        if (s_ren !== 8'b0000_0100 || m_rdata !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL arst pre s_ren/m_rdata got %b/%h want 00000100/deadbeef", s_ren, m_rdata);
        end
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if ({s_wen, s_ren, s_addr, s_wdata, m_ack, m_rdata} !== '0) begin
            n_bad++; $display("FAIL arst outputs got %h want 0",
                              {s_wen, s_ren, s_addr, s_wdata, m_ack, m_rdata});
        end
        @(negedge clk);
        rstn = 1'b1;
        s_ack = 8'b0000_0100;
        @(negedge clk);
        s_ack = '0;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (m_ack !== 1'b0) begin
                n_bad++; $display("FAIL arst no_ack c=%0d got %b want 0", c, m_ack);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int            slot, kind, noise;
            logic [AW-1:0] a;
            slot  = $urandom_range(0, SN - 1);
            kind  = $urandom_range(0, 2);
            noise = ($urandom_range(0, 1) == 1) ? (slot + 1 + $urandom_range(0, SN - 2)) % SN : -1;
            a = $urandom;
            a[22:20] = 3'(slot);
            access("rand", 1'(kind != 1), 1'(kind != 0), a, $urandom, $urandom,
                   $urandom_range(0, 12), noise, -1);
        end
    endtask

    initial begin
        test_reset();
        test_write_slot3();
        test_read_slot5();
        test_unpopulated();
        test_both_strobes();
        test_timeout_boundary();
        test_timeout();
        test_abandon();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sys_bus_interconnect.md
Name: sys_bus_interconnect

Overview:
- Sits directly downstream of the AXI-to-system-bus slave. Takes its single system-bus master port (wen/ren/addr/wdata in, rdata/ack out) and fans it out to SN subordinate register blocks, selected by an address field.
- Registers the request strobes and tracks one outstanding access. Returns exactly one registered ack and rdata per accepted access.
- Answers unpopulated slots itself. Discards stale or late subordinate acks.

Parameters:
- DW, 32, data width.
- AW, 32, address width.
- SN, 8, number of subordinate ports; power of two, 2..16.
- SL, $clog2(SN), select field width; derived, not overridable.
- AB, 20, LSB position of the select field in the address; AB+SL <= AW.
- MASK, {SN{1'b1}}, bit i=1 means slot i is populated.
- TMO, 40, cycles an access may stay pending before it is silently dropped.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- m_wen  in  1  write strobe from upstream, 1-cycle pulse.
- m_ren  in  1  read strobe from upstream, 1-cycle pulse.
- m_addr  in  AW  access address, valid with a strobe.
- m_wdata  in  DW  write data, valid with m_wen.
- m_rdata  out  DW  read data, valid with m_ack.
- m_ack  out  1  access complete, 1-cycle pulse.
- s_wen  out  SN  per-slot write strobe, one-hot or zero.
- s_ren  out  SN  per-slot read strobe, one-hot or zero.
- s_addr  out  AW  registered address, shared by all slots.
- s_wdata  out  DW  registered write data, shared by all slots.
- s_rdata  in  SN*DW  slot i read data in bits [i*DW +: DW].
- s_ack  in  SN  per-slot ack.

Behaviour:
- Reset: asynchronous, active low. Forces all of the following to zero: s_wen, s_ren, s_addr, s_wdata, m_ack, m_rdata, the state register, the latched slot index, the latched read flag and the timeout counter.
- Request capture, cycle N (m_wen|m_ren high):
  - sel = m_addr[AB +: SL].
  - s_addr <= m_addr (full address, select bits kept); s_wdata <= m_wdata.
  - Latch sel and a read flag (rd = m_ren & ~m_wen).
  - State <= PEND; timeout counter <= 0.
  - If m_wen and m_ren are both high, the access is treated as a write.
- Strobe, cycle N+1: s_wen[sel] or s_ren[sel] is high for exactly one cycle; all other strobe bits are 0.
- Unpopulated slot (MASK[sel]=0):
  - No strobe is issued.
  - m_ack=1 at N+2 with m_rdata=0; state returns to IDLE.
- States:
  - IDLE: no access outstanding.
  - PEND: waiting for s_ack[sel_q].
- In PEND, s_ack[sel_q] sampled high in cycle K gives, at K+1:
  - m_ack=1;
  - m_rdata = s_rdata slice sel_q if rd, else 0;
  - state -> IDLE.
  - Earliest case: ack in the strobe cycle N+1, m_ack at N+2.
- m_rdata holds its value until the next m_ack.
- Ignored acks: s_ack from any slot other than sel_q, and any s_ack while IDLE, are ignored.
- Timeout:
  - The counter increments every PEND cycle.
  - When it reaches TMO-1 with no ack, state -> IDLE with no m_ack; a later ack from that slot is ignored.
  - TMO exceeds the upstream 32-cycle timeout, so upstream has already completed the access by then.
- New request while PEND (upstream timed out and issued a new access):
  - The old access is abandoned and the new one is captured as from IDLE.
  - An s_ack[old] arriving in the same cycle is discarded; no m_ack is produced for the old access.
- Throughput: one access per 3 cycles minimum with zero-latency slots.
- Strobe exclusivity: m_ack and s_* strobes are never asserted for the abandoned access. At most one bit of s_wen|s_ren is ever high.

Test Plan:
- Write m_addr=0x0030_0010, m_wdata=0xA5A5_0001, slot 3 acks in the strobe cycle. Required: s_wen=8'b0000_1000 at N+1, s_addr=0x0030_0010, s_wdata=0xA5A5_0001, m_ack at N+2, m_rdata=0.
- Read slot 5 at 0x0050_0004; slot 5 acks 7 cycles after its strobe with s_rdata slice=0x1234_5678, while slot 2 pulses s_ack during the wait. Required: single m_ack one cycle after the slot-5 ack, m_rdata=0x1234_5678; the slot-2 ack produces nothing.
- MASK=8'b0111_1111, read 0x0070_0000. Required: no s_ren bit set, m_ack at N+2, m_rdata=0.
- Read slot 1 that never acks. Required: state returns to IDLE after 40 cycles with no m_ack; a slot-1 ack injected at cycle 50 produces no m_ack.
- Read slot 1 with no ack, then a new write to slot 4 at cycle 33 while slot 1 acks in that same cycle. Required: no m_ack for slot 1, s_wen[4] pulse, exactly one m_ack for the write.
- Assert rstn low mid-PEND, asynchronously between edges. Required: all outputs 0 immediately; a subsequent s_ack produces no m_ack.
